// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// rob_pkg : shared ROB widths and fill/broadcast record types
// Revision: 1.0
// ============================================================================
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int DATA_W    = 32;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        rob_tag_t            tag;
        logic [DATA_W-1:0]   data;
        logic                exc;
    } fill_req_t;

    typedef struct packed {
        logic                valid;
        rob_tag_t            tag;
        logic [DATA_W-1:0]   data;
    } bc_t;

endpackage
`default_nettype wire

// File: rtl/rob_fill_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot grant, search begins at ptr
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant_oh,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int j;
        j         = 0;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any         = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = PTR_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_fill_responder.sv
`default_nettype none
// ============================================================================
// rob_fill_responder : arbitrates RS fills into the ROB result store and
// broadcasts each accepted fill one cycle later for operand wakeup.
// Revision: 1.0
// ============================================================================
module rob_fill_responder
    import rob_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        fill_valid,
    output logic [N_REQ-1:0]        fill_ready,
    input  logic [N_REQ*TAG_W-1:0]  fill_tag,
    input  logic [N_REQ*DATA_W-1:0] fill_data,
    input  logic [N_REQ-1:0]        fill_exc,
    input  logic                    alloc_valid,
    input  logic [TAG_W-1:0]        alloc_tag,
    input  logic                    flush,
    input  logic [TAG_W-1:0]        head_tag,
    output logic                    head_done,
    output logic [DATA_W-1:0]       head_data,
    output logic                    head_exc,
    output logic                    bc_valid,
    output logic [TAG_W-1:0]        bc_tag,
    output logic [DATA_W-1:0]       bc_data,
    output logic                    err_dup_fill
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [N_REQ-1:0]     grant_oh;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 xfer;
    logic                 collide;
    logic                 dup;
    fill_req_t            sel;
    bc_t                  bc_q;
    logic [ROB_DEPTH-1:0] done;
    logic [ROB_DEPTH-1:0] done_next;
    logic [DATA_W-1:0]    data_mem [ROB_DEPTH];
    logic                 exc_mem  [ROB_DEPTH];

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
        .req       (fill_valid),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Gating with rst_n makes ready drop the instant reset asserts.
    assign fill_ready = (rst_n && !flush) ? grant_oh : '0;
    assign xfer       = grant_any && rst_n && !flush;

    always_comb begin
        sel.tag  = fill_tag[grant_idx*TAG_W +: TAG_W];
        sel.data = fill_data[grant_idx*DATA_W +: DATA_W];
        sel.exc  = fill_exc[grant_idx];
    end

    assign collide = xfer && alloc_valid && (alloc_tag == sel.tag);
    assign dup     = xfer && (done[sel.tag] || collide);

    // Alloc is applied after the fill so a same-tag alloc wins.
    always_comb begin
        done_next = done;
        if (xfer) begin
            done_next[sel.tag] = 1'b1;
        end
        if (alloc_valid) begin
            done_next[alloc_tag] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done         <= '0;
            err_dup_fill <= 1'b0;
            rr_ptr       <= '0;
            bc_q         <= '0;
        end else if (flush) begin
            done         <= '0;
            bc_q.valid   <= 1'b0;
        end else begin
            done       <= done_next;
            bc_q.valid <= xfer;
            if (xfer) begin
                bc_q.tag  <= sel.tag;
                bc_q.data <= sel.data;
                rr_ptr    <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (dup) begin
                err_dup_fill <= 1'b1;
            end
        end
    end

    // Result storage is deliberately unreset; done bits qualify it.
    always_ff @(posedge clk) begin
        if (xfer && !collide) begin
            data_mem[sel.tag] <= sel.data;
            exc_mem[sel.tag]  <= sel.exc;
        end
    end

    assign head_done = done[head_tag];
    assign head_data = data_mem[head_tag];
    assign head_exc  = exc_mem[head_tag];
    assign bc_valid  = bc_q.valid;
    assign bc_tag    = bc_q.tag;
    assign bc_data   = bc_q.data;

endmodule
`default_nettype wire

// File: tb/tb_rob_fill_responder.sv
`default_nettype none
// ============================================================================
// tb_rob_fill_responder : scoreboard bench, behavioural ROB fill model
// Revision: 1.0
// ============================================================================
module tb_rob_fill_responder;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int D  = 16;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    fill_valid, fill_ready, fill_exc;
    logic [N*TW-1:0] fill_tag;
    logic [N*DW-1:0] fill_data;
    logic            alloc_valid, flush;
    logic [TW-1:0]   alloc_tag, head_tag, bc_tag;
    logic            head_done, head_exc, bc_valid, err_dup_fill;
    logic [DW-1:0]   head_data, bc_data;

    logic            req_v    [N];
    logic [TW-1:0]   req_tag  [N];
    logic [DW-1:0]   req_data [N];
    logic            req_exc  [N];
    bit              refill;

    bit              m_done  [D];
    bit              m_known [D];
    logic [DW-1:0]   m_data  [D];
    bit              m_exc   [D];
    bit              m_err;
    int              m_ptr;
    logic [N-1:0]    exp_grant;
    int              cyc;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            due;
    } bc_exp_t;
    bc_exp_t sb[$];

    int tests = 0;
    int fails = 0;

    rob_fill_responder #(.N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_tag(fill_tag),
        .fill_data(fill_data), .fill_exc(fill_exc),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .flush(flush),
        .head_tag(head_tag), .head_done(head_done), .head_data(head_data), .head_exc(head_exc),
        .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
        .err_dup_fill(err_dup_fill)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            fill_valid[i]            = req_v[i];
            fill_exc[i]              = req_exc[i];
            fill_tag[i*TW +: TW]     = req_tag[i];
            fill_data[i*DW +: DW]    = req_data[i];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < D; t++) m_done[t] = 0;
        m_err     = 0;
        m_ptr     = 0;
        exp_grant = '0;
    endtask

    // Reference model: evaluates this cycle's inputs just before the edge that acts on them.
    always @(negedge clk) begin
        int g;
        int j;
        int t;
        bit coll;
        g = -1;
        if (!rst_n) begin
            exp_grant = '0;
            check("rst_fill_ready", fill_ready, 0);
            check("rst_bc_valid", bc_valid, 0);
            check("rst_head_done", head_done, 0);
            check("rst_err", err_dup_fill, 0);
        end else begin
            check("head_done", head_done, m_done[head_tag]);
            if (m_known[head_tag]) begin
                check("head_data", head_data, m_data[head_tag]);
                check("head_exc", head_exc, m_exc[head_tag]);
            end
            check("err_dup_fill", err_dup_fill, m_err);
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && req_v[j]) g = j;
                end
            end
            exp_grant = '0;
            if (g >= 0) exp_grant[g] = 1'b1;
            check("fill_ready", fill_ready, exp_grant);
            if (flush) begin
                for (int k = 0; k < D; k++) m_done[k] = 0;
            end else begin
                if (g >= 0) begin
                    t    = int'(req_tag[g]);
                    coll = alloc_valid && (alloc_tag == req_tag[g]);
                    if (m_done[t] || coll) m_err = 1;
                    if (!coll) begin
                        m_data[t]  = req_data[g];
                        m_exc[t]   = req_exc[g];
                        m_known[t] = 1;
                    end
                    m_done[t] = 1;
                    sb.push_back('{tag: req_tag[g], data: req_data[g], due: cyc + 1});
                    m_ptr = (g + 1) % N;
                end
                if (alloc_valid) m_done[alloc_tag] = 0;
            end
        end
    end

    // Broadcast monitor: pops the scoreboard whenever the DUT broadcasts.
    always @(negedge clk) begin
        bc_exp_t e;
        if (rst_n) begin
            while (sb.size() != 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                tests++; fails++;
                $display("FAIL bc_missing: got no broadcast, expected tag %0h data %0h", e.tag, e.data);
            end
            if (bc_valid) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bc_unexpected: got tag %0h, expected no broadcast", bc_tag);
                end else begin
                    e = sb.pop_front();
                    check("bc_tag", bc_tag, e.tag);
                    check("bc_data", bc_data, e.data);
                    check("bc_due", cyc, e.due);
                end
            end
        end
    end

    task automatic new_req(input int i, input int max_tag);
        req_v[i]    = 1'b1;
        req_tag[i]  = TW'($urandom_range(0, max_tag));
        req_data[i] = $urandom;
        req_exc[i]  = 1'($urandom_range(0, 1));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (exp_grant[i]) begin
                if (refill) new_req(i, D - 1);
                else        req_v[i] = 1'b0;
            end
        end
        alloc_valid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic mid_reset();
        cycle();
        #2;
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check("async_fill_ready", fill_ready, 0);
        check("async_bc_valid", bc_valid, 0);
        check("async_head_done", head_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input int tag, input logic [DW-1:0] data);
        req_v[i]    = 1'b1;
        req_tag[i]  = TW'(tag);
        req_data[i] = data;
        req_exc[i]  = 1'b0;
    endtask

    initial begin
        cyc = 0;
        refill = 0;
        for (int i = 0; i < N; i++) begin
            req_v[i] = 0; req_tag[i] = '0; req_data[i] = '0; req_exc[i] = 0;
        end
        for (int t = 0; t < D; t++) begin
            m_known[t] = 0; m_data[t] = '0; m_exc[t] = 0;
        end
        model_reset();
        alloc_valid = 0; alloc_tag = '0; flush = 0; head_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fill from requester 1
        set_req(1, 5, 32'hDEAD_BEEF);
        head_tag = 4'd5;
        repeat (3) cycle();

        // Reset mid-cycle with all requesters valid, then fairness from ptr 0
        refill = 1;
        for (int i = 0; i < N; i++) new_req(i, D - 1);
        mid_reset();
        repeat (5) cycle();
        refill = 0;
        for (int i = 0; i < N; i++) req_v[i] = 0;

        // Alloc/fill collision on tag 7
        mid_reset();
        set_req(0, 7, 32'h1234_5678);
        alloc_valid = 1'b1;
        alloc_tag   = 4'd7;
        head_tag    = 4'd7;
        repeat (3) cycle();

        // Duplicate fill to tag 3
        mid_reset();
        head_tag = 4'd3;
        set_req(2, 3, 32'd1);
        cycle();
        set_req(2, 3, 32'd2);
        repeat (2) cycle();

        // Fill tags 0..3, then flush with req0 pending
        mid_reset();
        for (int i = 0; i < N; i++) set_req(i, i, $urandom);
        head_tag = 4'd2;
        repeat (5) cycle();
        set_req(0, 9, 32'hCAFE_0009);
        flush    = 1'b1;
        head_tag = 4'd9;
        repeat (3) cycle();

        // Randomized traffic, narrow tag range to provoke duplicates
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++)
                if (!req_v[i] && $urandom_range(0, 2) == 0) new_req(i, 7);
            alloc_valid = ($urandom_range(0, 3) == 0);
            alloc_tag   = TW'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 19) == 0);
            head_tag    = TW'($urandom_range(0, D - 1));
            cycle();
        end

        for (int i = 0; i < N; i++) req_v[i] = 0;
        repeat (3) cycle();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
